// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start-edge synchronizer, four-state frame FSM and
// registered tx/busy/done outputs computed from the next state.
module uart_tx_8n1 #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600,
  parameter int SIZE     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] data,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_8n1: CLK_FREQ/BAUD must be at least 2");
  end
  if (SIZE != 8) begin : g_size_check
    $error("uart_tx_8n1: only SIZE=8 is supported");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic            r_s1, r_s2, r_s3;
  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [SIZE-1:0] r_shift;
  logic            r_tx, r_busy, r_done;

  logic            w_edge, w_bit_end;
  state_t          w_state_nx;
  logic [BW-1:0]   w_baud_nx;
  logic [2:0]      w_bit_nx;
  logic [SIZE-1:0] w_shift_nx;
  logic            w_tx_nx, w_done_nx;

  assign w_edge    = r_s2 & ~r_s3;
  assign w_bit_end = (r_baud == BAUD_LAST);

  // start synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= start;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // next-state, counters and shift register; tx follows the next state so
  // the registered line value lines up with the state register
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_done_nx  = 1'b0;
    w_tx_nx    = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_state_nx = START;
          w_baud_nx  = BW'(0);
          w_bit_nx   = 3'd0;
          w_shift_nx = data;
        end else begin
          w_state_nx = IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
          w_baud_nx  = BW'(0);
        end else begin
          w_baud_nx = r_baud + BW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nx  = BW'(0);
          w_shift_nx = {1'b0, r_shift[SIZE-1:1]};
          if (r_bit == 3'd7) begin
            w_state_nx = STOP;
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end else begin
          w_baud_nx = r_baud + BW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_nx = IDLE;
          w_baud_nx  = BW'(0);
          w_done_nx  = 1'b1;
        end else begin
          w_baud_nx = r_baud + BW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
    case (w_state_nx)
      START:   w_tx_nx = 1'b0;
      DATA:    w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

  // frame state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= BW'(0);
      r_bit   <= 3'd0;
      r_shift <= {SIZE{1'b0}};
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_done  <= w_done_nx;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1 at 4 clocks per bit; the expected line
// is built from the frame definition (start bit, LSB-first data, stop bit).
module tb_uart_tx_8n1;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done_cyc = 0;

  uart_tx_8n1 #(.CLK_FREQ(40), .BAUD(10), .SIZE(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // line value of bit slot 0..9 of a frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    else if (slot == 9) return 1'b1;
    else return b[slot-1];
  endfunction

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq({tag, "_tx"},   32'(tx),   32'd1);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
    end
  endtask

  // raise start with data b; tx must fall exactly after the third clock edge
  task automatic send(input logic [7:0] b, input bit hold, input string tag);
    data  = b;
    start = 1'b1;
    @(negedge clk);
    check_eq({tag, "_lat1"}, 32'({tx, busy}), 32'b10);
    @(negedge clk);
    check_eq({tag, "_lat2"}, 32'({tx, busy}), 32'b10);
    @(negedge clk);
    check_eq({tag, "_lat3"}, 32'({tx, busy}), 32'b01);
    if (!hold) start = 1'b0;
  endtask

  // entered at the negedge of the first tx=0 cycle; returns in the done cycle
  task automatic expect_frame(input logic [7:0] b, input string tag,
                              input int rise_at, input int fall_at,
                              input int chg_at, input logic [7:0] chg_val,
                              input bit scramble, input int abort_at);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i > 0) @(negedge clk);
      check_eq({tag, "_tx"},   32'(tx),   32'(frame_bit(b, i / CPB)));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      if (scramble) data = 8'($urandom);
      if (i == chg_at) data = chg_val;
      if (i == rise_at) start = 1'b1;
      if (i == fall_at) start = 1'b0;
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_abort"}, 32'({tx, busy, done}), 32'b100);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check_eq({tag, "_end"}, 32'({tx, busy, done}), 32'b101);
    last_done_cyc = cyc;
  endtask

  initial begin
    int t1;
    logic [7:0] b;
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset", 32'({tx, busy, done}), 32'b100);
    rst = 1'b0;
    idle_cycles(3, "idle0");

    // basic frame of 0x61
    send(8'h61, 1'b0, "f61");
    expect_frame(8'h61, "f61", -1, -1, -1, 8'h00, 1'b0, -1);
    idle_cycles(5, "f61_after");

    // data changes after acceptance
    send(8'h61, 1'b0, "chg");
    expect_frame(8'h61, "chg", -1, -1, 10, 8'h62, 1'b0, -1);
    idle_cycles(5, "chg_after");

    // a second start rise mid-frame is dropped
    send(8'h5A, 1'b0, "ign");
    expect_frame(8'h5A, "ign", 15, 18, -1, 8'h00, 1'b0, -1);
    idle_cycles(60, "ign_after");

    // start held high: one frame only
    send(8'h7A, 1'b1, "hold");
    expect_frame(8'h7A, "hold", -1, -1, -1, 8'h00, 1'b0, -1);
    idle_cycles(160, "hold_after");
    start = 1'b0;
    idle_cycles(3, "hold_rel");

    // rise lands in the done cycle: next frame follows the done cycle directly
    send(8'hC3, 1'b0, "b2b1");
    expect_frame(8'hC3, "b2b1", 38, -1, -1, 8'h00, 1'b0, -1);
    t1 = last_done_cyc;
    data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    expect_frame(8'h3C, "b2b2", -1, -1, -1, 8'h00, 1'b0, -1);
    // 40 frame cycles plus the done cycle separate the pulses
    check_eq("b2b_gap", 32'(last_done_cyc - t1), 32'd41);
    idle_cycles(5, "b2b_after");

    // asynchronous reset during data bit 3 aborts without done
    send(8'hA5, 1'b0, "abort");
    expect_frame(8'hA5, "abort", -1, -1, -1, 8'h00, 1'b0, 17);
    idle_cycles(50, "abort_after");

    // start already high when reset releases yields exactly one frame
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h96;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rsthi_lat1", 32'({tx, busy}), 32'b10);
    @(negedge clk);
    check_eq("rsthi_lat2", 32'({tx, busy}), 32'b10);
    @(negedge clk);
    check_eq("rsthi_lat3", 32'({tx, busy}), 32'b01);
    expect_frame(8'h96, "rsthi", -1, -1, -1, 8'h00, 1'b0, -1);
    idle_cycles(30, "rsthi_after");
    start = 1'b0;
    idle_cycles(3, "rsthi_rel");

    // random bytes, gaps and data churn during frames
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send(b, 1'b0, "rnd");
      expect_frame(b, "rnd", -1, -1, -1, 8'h00, 1'b1, -1);
      idle_cycles(int'($urandom_range(1, 6)), "rnd_gap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
